poly_scale: RTL and testbench
=============================

Name: poly_scale

Overview:
- Polyphonic successor to the single-voice keyboard tone generator.
- Consumes a PS/2 set-2 scan-code byte stream.
- Tracks make/break per key and allocates up to NUM_VOICES simultaneous square-wave voices.
- Drives a 1-bit speaker plus a mix level, and sits between the PS/2 receiver and the audio pin.

Parameters:
- NUM_VOICES, 4, number of simultaneous tone voices (1..8).
- CNT_W, 18, width of the period register and counter per voice; must hold 190839.
- MAX_SHIFT, 2, largest accepted value of oct_shift.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- piano  in  1  output enable; gates speaker and mix_level only
- code_byte  in  8  scan-code byte from the PS/2 receiver
- code_valid  in  1  one-cycle strobe; code_byte is valid this cycle
- oct_shift  in  2  octave-up shift; the note period is shifted right by this amount
- voice_active  out  NUM_VOICES  per-voice held flag
- speaker  out  1  piano AND (OR of all voice tones)
- mix_level  out  $clog2(NUM_VOICES+1)  piano ? popcount(voice tones) : 0

Behaviour:
- Reset: all voices inactive, tones 0, counters 0, FSM in IDLE, steal_ptr 0. Outputs after reset: voice_active=0, speaker=0, mix_level=0. rst wins over a simultaneous code_valid.
- Decoder FSM, advances only on code_valid:
  - IDLE: F0 -> BRK; E0 -> EXT; any other byte is a make code, processed, stay in IDLE.
  - BRK: any byte is a break code, processed -> IDLE.
  - EXT: F0 -> EXT_BRK; any other byte is discarded -> IDLE.
  - EXT_BRK: any byte is discarded -> IDLE. Extended keys are never notes.
- Note table: 36 entries, code:P.
  - 16:190839 1E:180505 26:170068 25:160771 2E:151515 36:143266 3D:135135 3E:127551 46:120481 45:113636 4E:107296 55:101214
  - 15:95602 1D:90252 24:85178 2D:80385 2C:75872 35:71633 3C:67567 43:63775 44:60168 4D:56818 54:54171 5B:50607
  - 1C:47755 1B:45085 23:42553 2B:40160 34:37622 33:35790 3B:33783 42:31887 4B:30102 4C:28409 52:26809 5A:25303
- Make, mapped code:
  - Code already held by a voice: ignore (typematic repeat).
  - Otherwise, if any voice is free: allocate the lowest-index free voice.
  - Otherwise: steal voice steal_ptr, then steal_ptr <= (steal_ptr+1) mod NUM_VOICES.
  - Allocated voice: key<=code, period<=P>>min(oct_shift,MAX_SHIFT), counter<=0, tone<=0, active<=1.
- Make 29 (space): all-notes-off; every voice active<=0, tone<=0. Break 29 has no effect.
- Make or break of 00 or any unmapped code: no voice change.
- Break of a mapped code: the voice holding that code goes active<=0, tone<=0, counter<=0. If no voice holds it, no change.
- Latency: voice_active reflects a byte on the cycle after its code_valid.
- Voice tone, while active:
  - counter==period: tone toggles, counter<=0; otherwise counter+1.
  - Half-period is period+1 clocks.
  - Voices with period<2 stay silent.
- oct_shift is sampled only at allocation; changing it does not retune held notes.
- piano=0 silences the outputs only; voices keep counting, so phase is preserved on re-enable.
- Counter width is CNT_W, unsigned; no wrap is possible because period fits CNT_W.

Test Plan:
- rst high 3 cycles, then low -> voice_active=0, speaker=0, mix_level=0; hold 1000 cycles with no input, outputs unchanged.
- piano=1, oct_shift=0, byte 16 -> voice_active=0001 next cycle; speaker rises 190840 clocks after allocation and toggles every 190840 clocks; bytes F0,16 -> voice_active=0000, speaker=0.
- Makes 16,1E,26,25 then 2E with NUM_VOICES=4 -> voice 0 stolen for 2E, steal_ptr=1; a second make 1E is ignored; mix_level=4 once all four tones are high together.
- oct_shift=2, make 1C -> half-period 11939 clocks; change oct_shift to 0 while held -> half-period still 11939.
- Sequences E0,16 and E0,F0,16, plus bytes 00 and 0E -> no voice change, FSM back in IDLE; then make 29 with 3 voices held -> voice_active=0 next cycle.
- code_valid with byte 16 in the same cycle as rst=1 -> voice_active stays 0; piano=0 with a voice held -> speaker=0, mix_level=0, voice_active=1.

Source files
------------

// File: rtl/poly_scale_if.sv
// rtl/poly_scale_if.sv - scan-code input and audio output bundle for poly_scale
interface poly_scale_if #(
  parameter int NUM_VOICES = 4
);
  localparam int MIX_W = $clog2(NUM_VOICES + 1);

  logic                  piano;
  logic [7:0]            code_byte;
  logic                  code_valid;
  logic [1:0]            oct_shift;
  logic [NUM_VOICES-1:0] voice_active;
  logic                  speaker;
  logic [MIX_W-1:0]      mix_level;

  modport master (
    output piano, code_byte, code_valid, oct_shift,
    input  voice_active, speaker, mix_level
  );

  modport slave (
    input  piano, code_byte, code_valid, oct_shift,
    output voice_active, speaker, mix_level
  );
endinterface

// File: rtl/poly_scale.sv
// rtl/poly_scale.sv - PS/2 set-2 scan codes to NUM_VOICES square-wave voices
module poly_scale #(
  parameter int NUM_VOICES = 4,
  parameter int CNT_W      = 18,
  parameter int MAX_SHIFT  = 2
) (
  input logic         clk,
  input logic         rst,
  poly_scale_if.slave bus
);
  localparam int SPW   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int MIX_W = $clog2(NUM_VOICES + 1);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t                state, state_nxt;
  logic [SPW-1:0]        steal_ptr;
  logic [NUM_VOICES-1:0] active, tone;
  logic [7:0]            key    [NUM_VOICES];
  logic [CNT_W-1:0]      period [NUM_VOICES];
  logic [CNT_W-1:0]      cnt    [NUM_VOICES];

  logic                  make_ev, brk_ev;
  logic [CNT_W-1:0]      note_p, shifted_p;
  logic                  note_ok;
  logic [1:0]            sh;
  logic [NUM_VOICES-1:0] held_hit;
  logic                  any_free;
  logic [SPW-1:0]        free_idx, alloc_idx;
  logic                  do_alloc, do_off, do_brk;
  logic [MIX_W-1:0]      tone_cnt;

  // A zero period marks an unmapped code; every real note period is nonzero.
  function automatic logic [CNT_W-1:0] note_period(input logic [7:0] c);
    case (c)
      8'h16: note_period = CNT_W'(190839);
      8'h1E: note_period = CNT_W'(180505);
      8'h26: note_period = CNT_W'(170068);
      8'h25: note_period = CNT_W'(160771);
      8'h2E: note_period = CNT_W'(151515);
      8'h36: note_period = CNT_W'(143266);
      8'h3D: note_period = CNT_W'(135135);
      8'h3E: note_period = CNT_W'(127551);
      8'h46: note_period = CNT_W'(120481);
      8'h45: note_period = CNT_W'(113636);
      8'h4E: note_period = CNT_W'(107296);
      8'h55: note_period = CNT_W'(101214);
      8'h15: note_period = CNT_W'(95602);
      8'h1D: note_period = CNT_W'(90252);
      8'h24: note_period = CNT_W'(85178);
      8'h2D: note_period = CNT_W'(80385);
      8'h2C: note_period = CNT_W'(75872);
      8'h35: note_period = CNT_W'(71633);
      8'h3C: note_period = CNT_W'(67567);
      8'h43: note_period = CNT_W'(63775);
      8'h44: note_period = CNT_W'(60168);
      8'h4D: note_period = CNT_W'(56818);
      8'h54: note_period = CNT_W'(54171);
      8'h5B: note_period = CNT_W'(50607);
      8'h1C: note_period = CNT_W'(47755);
      8'h1B: note_period = CNT_W'(45085);
      8'h23: note_period = CNT_W'(42553);
      8'h2B: note_period = CNT_W'(40160);
      8'h34: note_period = CNT_W'(37622);
      8'h33: note_period = CNT_W'(35790);
      8'h3B: note_period = CNT_W'(33783);
      8'h42: note_period = CNT_W'(31887);
      8'h4B: note_period = CNT_W'(30102);
      8'h4C: note_period = CNT_W'(28409);
      8'h52: note_period = CNT_W'(26809);
      8'h5A: note_period = CNT_W'(25303);
      default: note_period = '0;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    make_ev   = 1'b0;
    brk_ev    = 1'b0;
    if (bus.code_valid) begin
      case (state)
        IDLE: begin
          if (bus.code_byte == 8'hF0)      state_nxt = BRK;
          else if (bus.code_byte == 8'hE0) state_nxt = EXT;
          else                             make_ev   = 1'b1;
        end
        BRK: begin
          brk_ev    = 1'b1;
          state_nxt = IDLE;
        end
        EXT:     state_nxt = (bus.code_byte == 8'hF0) ? EXT_BRK : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    note_p    = note_period(bus.code_byte);
    note_ok   = (note_p != '0);
    sh        = (int'(bus.oct_shift) > MAX_SHIFT) ? 2'(MAX_SHIFT) : bus.oct_shift;
    shifted_p = note_p >> sh;
    held_hit  = '0;
    any_free  = 1'b0;
    free_idx  = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      held_hit[i] = active[i] && (key[i] == bus.code_byte);
    // Scan from the top so the lowest free index is the one left standing.
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!active[i]) begin
        any_free = 1'b1;
        free_idx = SPW'(i);
      end
    end
    alloc_idx = any_free ? free_idx : steal_ptr;
    do_alloc  = make_ev && note_ok && (held_hit == '0);
    do_off    = make_ev && (bus.code_byte == 8'h29);
    do_brk    = brk_ev && note_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      steal_ptr <= '0;
      active    <= '0;
      tone      <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        key[i]    <= '0;
        period[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      state <= state_nxt;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (active[i]) begin
          if (period[i] < CNT_W'(2)) begin
            tone[i] <= 1'b0;
            cnt[i]  <= '0;
          end else if (cnt[i] == period[i]) begin
            tone[i] <= ~tone[i];
            cnt[i]  <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
        if (do_off) begin
          active[i] <= 1'b0;
          tone[i]   <= 1'b0;
        end
        if (do_brk && held_hit[i]) begin
          active[i] <= 1'b0;
          tone[i]   <= 1'b0;
          cnt[i]    <= '0;
        end
        if (do_alloc && (alloc_idx == SPW'(i))) begin
          key[i]    <= bus.code_byte;
          period[i] <= shifted_p;
          cnt[i]    <= '0;
          tone[i]   <= 1'b0;
          active[i] <= 1'b1;
        end
      end
      if (do_alloc && !any_free)
        steal_ptr <= (steal_ptr == SPW'(NUM_VOICES - 1)) ? '0 : steal_ptr + 1'b1;
    end
  end

  always_comb begin
    tone_cnt = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      tone_cnt = tone_cnt + MIX_W'(tone[i]);
  end

  assign bus.voice_active = active;
  assign bus.speaker      = bus.piano & (|tone);
  assign bus.mix_level    = bus.piano ? tone_cnt : '0;
endmodule

// File: tb/tb_poly_scale.sv
// tb/tb_poly_scale.sv - directed scoreboard bench for poly_scale
module tb_poly_scale;
  localparam int NV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [NV-1:0] exp_q [$];

  always #5 clk = ~clk;

  poly_scale_if #(.NUM_VOICES(NV)) bus ();

  poly_scale #(.NUM_VOICES(NV), .CNT_W(18), .MAX_SHIFT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected voice_active is queued with the byte, then popped once the DUT has registered it.
  task automatic send(input logic [7:0] b, input logic [NV-1:0] exp);
    logic [NV-1:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.code_byte  = b;
    bus.code_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.code_valid = 1'b0;
    e = exp_q.pop_front();
    check($sformatf("voice_active after byte %02h", b), 32'(bus.voice_active), 32'(e));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.piano      = 1'b0;
    bus.code_byte  = 8'h00;
    bus.code_valid = 1'b0;
    bus.oct_shift  = 2'd0;

    do_reset();
    check("reset voice_active", 32'(bus.voice_active), 32'h0);
    check("reset speaker", 32'(bus.speaker), 32'h0);
    check("reset mix_level", 32'(bus.mix_level), 32'h0);
    wait_edges(1000);
    check("idle voice_active", 32'(bus.voice_active), 32'h0);
    check("idle speaker", 32'(bus.speaker), 32'h0);

    // single voice, make then break
    bus.piano = 1'b1;
    send(8'h16, 4'b0001);
    check("fresh voice speaker", 32'(bus.speaker), 32'h0);
    send(8'hF0, 4'b0001);
    send(8'h16, 4'b0000);
    check("released speaker", 32'(bus.speaker), 32'h0);

    // 5A at shift 0: period 25303, rises 25304 clocks after allocation
    send(8'h5A, 4'b0001);
    wait_edges(25303);
    check("5A before rise", 32'(bus.speaker), 32'h0);
    wait_edges(1);
    check("5A rise", 32'(bus.speaker), 32'h1);
    check("5A mix", 32'(bus.mix_level), 32'h1);
    send(8'hF0, 4'b0001);
    send(8'h5A, 4'b0000);

    // voice stealing and typematic repeat
    send(8'h16, 4'b0001);
    send(8'h1E, 4'b0011);
    send(8'h26, 4'b0111);
    send(8'h25, 4'b1111);
    send(8'h2E, 4'b1111);
    send(8'h1E, 4'b1111);
    send(8'hF0, 4'b1111);
    send(8'h16, 4'b1111);
    send(8'hF0, 4'b1111);
    send(8'h2E, 4'b1110);
    send(8'h36, 4'b1111);
    send(8'h3D, 4'b1111);
    send(8'hF0, 4'b1111);
    send(8'h1E, 4'b1111);
    send(8'hF0, 4'b1111);
    send(8'h3D, 4'b1101);

    // four short voices at shift 2; all high together between +7529 and +12652
    do_reset();
    bus.piano     = 1'b1;
    bus.oct_shift = 2'd2;
    send(8'h5A, 4'b0001);
    send(8'h52, 4'b0011);
    send(8'h4C, 4'b0111);
    send(8'h4B, 4'b1111);
    wait_edges(6497);
    check("mix one voice high", 32'(bus.mix_level), 32'h1);
    wait_edges(1500);
    check("mix all high", 32'(bus.mix_level), 32'h4);
    check("speaker all high", 32'(bus.speaker), 32'h1);
    bus.piano = 1'b0;
    #1;
    check("muted speaker", 32'(bus.speaker), 32'h0);
    check("muted mix", 32'(bus.mix_level), 32'h0);
    check("muted voice_active", 32'(bus.voice_active), 32'hF);
    bus.piano = 1'b1;
    #1;
    check("unmuted mix", 32'(bus.mix_level), 32'h4);

    // octave shift sampled only at allocation: 47755>>2 = 11938, half-period 11939
    do_reset();
    send(8'h1C, 4'b0001);
    wait_edges(11938);
    check("1C before rise", 32'(bus.speaker), 32'h0);
    wait_edges(1);
    check("1C rise", 32'(bus.speaker), 32'h1);
    bus.oct_shift = 2'd0;
    wait_edges(11938);
    check("1C before fall", 32'(bus.speaker), 32'h1);
    wait_edges(1);
    check("1C fall", 32'(bus.speaker), 32'h0);

    // extended keys and unmapped codes leave voices alone
    send(8'hE0, 4'b0001);
    send(8'h16, 4'b0001);
    send(8'hE0, 4'b0001);
    send(8'hF0, 4'b0001);
    send(8'h16, 4'b0001);
    send(8'h00, 4'b0001);
    send(8'h0E, 4'b0001);
    send(8'hF0, 4'b0001);
    send(8'h00, 4'b0001);
    send(8'h16, 4'b0011);
    send(8'h1E, 4'b0111);
    send(8'h29, 4'b0000);
    check("all-off speaker", 32'(bus.speaker), 32'h0);
    send(8'hF0, 4'b0000);
    send(8'h29, 4'b0000);
    send(8'h26, 4'b0001);

    // reset beats a simultaneous code_valid
    @(negedge clk);
    rst            = 1'b1;
    bus.code_byte  = 8'h16;
    bus.code_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.code_valid = 1'b0;
    check("rst over valid", 32'(bus.voice_active), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    send(8'h16, 4'b0001);

    check("scoreboard drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
